// File: rtl/bram_port_arbiter_if.sv
// Bundle of both requester buses plus the shared RAM port seen by bram_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters/RAM side.
interface bram_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  last0, last1;
  logic                  gnt0, gnt1;
  logic                  rvalid0, rvalid1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, last0, last1, ram_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, last0, last1, ram_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one block-RAM port between two burst requesters.
// Define BRAM_ARB_BURST_LIMIT_EN to cap each ownership at MAX_BURST beats.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int MAX_BURST  = 16
) (
  input logic               clk,
  input logic               rst_n,
  bram_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

`ifdef BRAM_ARB_BURST_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  state_t     state;
  logic       prio;
  logic       owner;
  logic       rd0, rd1;
  logic [7:0] beat_cnt;
  logic       beat0, beat1;
  logic       burst_done;

  assign beat0      = (state == OWN0) && bus.req0;
  assign beat1      = (state == OWN1) && bus.req1;
  assign burst_done = LIMIT_EN && (beat_cnt == BURST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      owner    <= 1'b0;
      beat_cnt <= 8'd0;
      rd0      <= 1'b0;
      rd1      <= 1'b0;
    end else begin
      rd0 <= beat0 && !bus.we0;
      rd1 <= beat1 && !bus.we1;
      case (state)
        IDLE: begin
          beat_cnt <= 8'd0;
          if (bus.req0 && (!bus.req1 || !prio)) begin
            state <= OWN0;
            prio  <= 1'b1;
            owner <= 1'b0;
          end else if (bus.req1) begin
            state <= OWN1;
            prio  <= 1'b0;
            owner <= 1'b1;
          end
        end
        OWN0: begin
          if (!bus.req0) begin
            state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            if (bus.last0 || burst_done) state <= IDLE;
          end
        end
        OWN1: begin
          if (!bus.req1) begin
            state <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + 8'd1;
            if (bus.last1 || burst_done) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Address/data follow the most recent owner; only ram_we needs to be exact outside a beat.
  assign bus.gnt0      = (state == OWN0);
  assign bus.gnt1      = (state == OWN1);
  assign bus.ram_we    = (beat0 && bus.we0) || (beat1 && bus.we1);
  assign bus.ram_addr  = owner ? bus.addr1  : bus.addr0;
  assign bus.ram_wdata = owner ? bus.wdata1 : bus.wdata0;
  assign bus.rvalid0   = rd0;
  assign bus.rvalid1   = rd1;
  assign bus.rdata0    = bus.ram_rdata;
  assign bus.rdata1    = bus.ram_rdata;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: vector table for single-cycle behaviour,
// hand sequences for long bursts and mid-burst reset, with a small RAM model.
module tb_bram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [7:0] mem [64];

  bram_port_arbiter_if #(.DATA_WIDTH(8), .ADDR_WIDTH(6)) bus ();

  bram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .MAX_BURST(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Read-first synchronous RAM with one clock of read latency
  always @(posedge clk) begin
    bus.ram_rdata <= mem[bus.ram_addr];
    if (bus.ram_we) mem[bus.ram_addr] = bus.ram_wdata;
  end

  typedef struct {
    logic       do_reset;
    logic       req0, req1, we0, we1, last0, last1;
    logic [5:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, ram_we, rvalid0, rvalid1;
    logic       chk_addr;
    logic [5:0] ram_addr;
    logic       chk_rdata;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic rs, r0, r1, w0, w1, l0, l1,
    input logic [5:0] a0, a1, input logic [7:0] d0, d1,
    input logic g0, g1, we, v0, v1,
    input logic ca, input logic [5:0] ea, input logic cd, input logic [7:0] ed);
    vec_t v;
    v.do_reset = rs; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
    v.last0 = l0; v.last1 = l1; v.addr0 = a0; v.addr1 = a1;
    v.wdata0 = d0; v.wdata1 = d1; v.gnt0 = g0; v.gnt1 = g1; v.ram_we = we;
    v.rvalid0 = v0; v.rvalid1 = v1; v.chk_addr = ca; v.ram_addr = ea;
    v.chk_rdata = cd; v.rdata = ed;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.last0 = 0; bus.last1 = 0; bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    if (v.do_reset) pulse_reset();
    @(posedge clk); #1;
    bus.req0 = v.req0; bus.req1 = v.req1; bus.we0 = v.we0; bus.we1 = v.we1;
    bus.last0 = v.last0; bus.last1 = v.last1; bus.addr0 = v.addr0; bus.addr1 = v.addr1;
    bus.wdata0 = v.wdata0; bus.wdata1 = v.wdata1;
    #3;
    check_output($sformatf("v%0d_gnt0", idx), bus.gnt0, v.gnt0);
    check_output($sformatf("v%0d_gnt1", idx), bus.gnt1, v.gnt1);
    check_output($sformatf("v%0d_ram_we", idx), bus.ram_we, v.ram_we);
    check_output($sformatf("v%0d_rvalid0", idx), bus.rvalid0, v.rvalid0);
    check_output($sformatf("v%0d_rvalid1", idx), bus.rvalid1, v.rvalid1);
    if (v.chk_addr) check_output($sformatf("v%0d_ram_addr", idx), bus.ram_addr, v.ram_addr);
    if (v.chk_rdata) begin
      check_output($sformatf("v%0d_rdata0", idx), bus.rdata0, v.rdata);
      check_output($sformatf("v%0d_rdata1", idx), bus.rdata1, v.rdata);
    end
  endtask

  // 20-beat read burst; with the limit compiled in it splits 16 + 4 across two grants
  task automatic run_burst();
    int beats = 0, rv = 0, grants = 0, first_beats = 0, tail = 0, cyc = 0;
    logic prev_gnt = 1'b0;
    pulse_reset();
    for (int i = 0; i < 20; i++) mem[32 + i] = 8'(8'hC0 + i);
    while (tail < 2 && cyc < 80) begin
      @(posedge clk); #1;
      bus.req0 = (beats < 20); bus.we0 = 1'b0;
      bus.addr0 = 6'(32 + beats); bus.last0 = (beats == 19);
      #3;
      if (bus.gnt0 && !prev_gnt) grants++;
      prev_gnt = bus.gnt0;
      if (beats == 20) tail++;
      if (bus.rvalid0) begin
        check_output($sformatf("burst_rdata%0d", rv), bus.rdata0, 8'(8'hC0 + rv));
        rv++;
      end
      if (bus.gnt0 && bus.req0) begin
        beats++;
        if (grants == 1) first_beats++;
      end
      cyc++;
    end
    check_output("burst_timeout", (tail >= 2), 1);
    check_output("burst_beats", beats, 20);
    check_output("burst_rvalids", rv, 20);
`ifdef BRAM_ARB_BURST_LIMIT_EN
    check_output("burst_grants", grants, 2);
    check_output("burst_first_grant_beats", first_beats, 16);
`else
    check_output("burst_grants", grants, 1);
    check_output("burst_first_grant_beats", first_beats, 20);
`endif
    drive_idle();
  endtask

  task automatic run_reset_mid_burst();
    pulse_reset();
    @(posedge clk); #1;
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 6'd0; bus.last0 = 1'b0;
    @(posedge clk); #1 bus.addr0 = 6'd0;
    @(posedge clk); #1 bus.addr0 = 6'd1;
    @(posedge clk); #1 bus.addr0 = 6'd2;
    #2;
    check_output("rst_pre_gnt0", bus.gnt0, 1);
    check_output("rst_pre_rvalid0", bus.rvalid0, 1);
    rst_n = 1'b0;
    #1;
    check_output("rst_gnt0", bus.gnt0, 0);
    check_output("rst_gnt1", bus.gnt1, 0);
    check_output("rst_rvalid0", bus.rvalid0, 0);
    check_output("rst_ram_we", bus.ram_we, 0);
    bus.req1 = 1'b1; bus.we1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #3;
    check_output("rst_tie_gnt0", bus.gnt0, 1);
    check_output("rst_tie_gnt1", bus.gnt1, 0);
    drive_idle();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    mem[5] = 8'hA5;
    drive_idle();
    #3;
    check_output("reset_gnt0", bus.gnt0, 0);
    check_output("reset_gnt1", bus.gnt1, 0);
    check_output("reset_rvalid0", bus.rvalid0, 0);
    check_output("reset_rvalid1", bus.rvalid1, 0);
    check_output("reset_ram_we", bus.ram_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //              rs r0 r1 w0 w1 l0 l1 a0     a1     d0     d1      g0 g1 we v0 v1 ca ea     cd ed
    // Tie: req0 wins, 4 writes, dead cycle where req0 re-requests and req1 wins, req0 reads back
    vecs.push_back(mk(1, 1, 1, 1, 1, 0, 0, 6'h00, 6'h10, 8'h10, 8'h20, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h00, 6'h10, 8'h10, 8'h20, 1, 0, 1, 0, 0, 1, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h01, 6'h10, 8'h11, 8'h20, 1, 0, 1, 0, 0, 1, 6'h01, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h02, 6'h10, 8'h12, 8'h20, 1, 0, 1, 0, 0, 1, 6'h02, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 6'h03, 6'h10, 8'h13, 8'h20, 1, 0, 1, 0, 0, 1, 6'h03, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h00, 6'h10, 8'h00, 8'h20, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h00, 6'h10, 8'h00, 8'h20, 0, 1, 1, 0, 0, 1, 6'h10, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h00, 6'h11, 8'h00, 8'h21, 0, 1, 1, 0, 0, 1, 6'h11, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 0, 6'h00, 6'h12, 8'h00, 8'h22, 0, 1, 1, 0, 0, 1, 6'h12, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 1, 6'h00, 6'h13, 8'h00, 8'h23, 0, 1, 1, 0, 0, 1, 6'h13, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6'h02, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6'h02, 6'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 6'h02, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 6'h00, 1, 8'h12));
    // Single read of 0xA5 at 0x05; rvalid lands while already back in IDLE
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 6'h05, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6'h05, 6'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 6'h05, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 6'h00, 1, 8'hA5));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    // Abandon: req1 writes 2 beats then drops; pending req0 reads what was written
    vecs.push_back(mk(1, 0, 1, 0, 1, 0, 0, 6'h00, 6'h30, 8'h00, 8'h55, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 6'h30, 6'h30, 8'h00, 8'h55, 0, 1, 1, 0, 0, 1, 6'h30, 0, 8'h00));
    vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0, 6'h30, 6'h31, 8'h00, 8'h56, 0, 1, 1, 0, 0, 1, 6'h31, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 1, 1, 0, 6'h30, 6'h32, 8'h00, 8'h57, 0, 1, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6'h30, 6'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 6'h00, 0, 8'h00));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 6'h30, 6'h00, 8'h00, 8'h00, 1, 0, 0, 0, 0, 1, 6'h30, 0, 8'h00));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 6'h00, 6'h00, 8'h00, 8'h00, 0, 0, 0, 1, 0, 0, 6'h00, 1, 8'h55));

    for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

    run_burst();
    run_reset_mid_burst();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
# bram_port_arbiter

Two-requester round-robin arbiter that shares one port of the inferred dual-port block RAM between two on-chip masters (e.g. an acquisition writer and a USB readback engine). Grants burst ownership, muxes address/data/write-enable onto the RAM port, and routes the one-cycle-latency read data back to the requester that issued the read, tagged with a valid strobe. Sits directly in front of RAM port A or B; the other RAM port is unaffected.

## Interface
- DATA_WIDTH, 8, RAM word width; matches the RAM instance.
- ADDR_WIDTH, 6, RAM address width; matches the RAM instance.
- MAX_BURST, 16, maximum beats per grant when the burst limit is compiled in; range 1..256.

- clk  in  1  single clock; RAM port clock is the same clk.
- rst_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  requester i wants the port; held high for the whole burst.
- we0 / we1  in  1  beat is a write (1) or read (0).
- addr0 / addr1  in  ADDR_WIDTH  beat address.
- wdata0 / wdata1  in  DATA_WIDTH  write data.
- last0 / last1  in  1  marks final beat of the burst.
- gnt0 / gnt1  out  1  requester i owns the port; beat transfers when req_i & gnt_i.
- rvalid0 / rvalid1  out  1  read data for requester i valid this cycle.
- rdata0 / rdata1  out  DATA_WIDTH  read data (pass-through of ram_rdata).
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_WIDTH  to RAM addr.
- ram_wdata  out  DATA_WIDTH  to RAM data.
- ram_rdata  in  DATA_WIDTH  from RAM q.

## Operation
- States: IDLE, OWN0, OWN1. gnt_i = (state == OWNi), combinational decode of registered state.
- IDLE: if exactly one req high, go to its OWN state. If both high, winner = priority pointer `prio` (0 or 1); on entering OWNi, prio <= ~i. If none, stay.
- OWNi: each cycle with req_i high is one beat; ram_addr/ram_wdata = requester i's inputs, ram_we = we_i. Leave to IDLE when: beat with last_i = 1; or req_i low (abandon, no beat); or burst limit hit (see Configuration).
- Outside a beat: ram_we = 0; ram_addr/ram_wdata hold mux of last owner (don't-care, but ram_we must be 0).
- Read return: read beat in cycle N sets registered flag rd_i; rvalid_i = 1 in cycle N+1, rdata_i = ram_rdata. Write beats never raise rvalid. rdata0/rdata1 both equal ram_rdata at all times; only rvalid qualifies.
- Beat counter (8 bits) cleared on entering OWNi, incremented per beat.
- Addresses pass unmodified; wrap-around is the requester's concern.

## Timing
- Reset values: state IDLE, prio 0 (req0 wins first tie), gnt0/gnt1 0, rvalid0/rvalid1 0, beat counter 0, ram_we 0.
- Request to grant: req rising in cycle N (IDLE) -> gnt in cycle N+1. One dead IDLE cycle between any two ownerships, including back-to-back bursts by the same requester.
- Throughput: one beat per clock while owned.
- Read latency: one clock, beat to rvalid.
- Read beat on the final beat: rvalid still asserted next cycle while state is IDLE.
- Reset asserted mid-burst: all outputs return to reset values immediately (async); a pending rvalid is dropped.

## Configuration
- BRAM_ARB_BURST_LIMIT_EN defined: ownership ends after MAX_BURST beats even without last_i; requester sees gnt_i fall and must re-request for the remainder.
- Not defined: bursts are unbounded; only last_i or req_i low ends ownership. MAX_BURST is ignored.

## Test plan
- Single read: req0, we0=0, addr0=0x05, last0=1, RAM holds 0xA5 -> gnt0 one cycle after req0, ram_addr=0x05, ram_we=0, rvalid0 next cycle with rdata0=0xA5, rvalid1 stays 0.
- Tie: req0 and req1 rise same cycle, each 4-beat write burst -> OWN0 first (4 beats, addr 0..3), one IDLE cycle, then OWN1; next tie grants req1 first.
- Abandon: req1 owns, drops req1 after 2 of 5 beats -> exactly 2 ram_we pulses, state IDLE next cycle, pending req0 granted the cycle after.
- Burst limit (macro defined, MAX_BURST=16): req0 20-beat read, last0 only on beat 20 -> gnt0 falls after beat 16, 16 rvalid0 pulses, re-request completes remaining 4.
- Same stimulus with macro undefined -> single 20-beat grant, 20 rvalid0 pulses.
- Reset mid-burst: rst_n low during beat 3 of a read burst -> gnt0, rvalid0, ram_we 0 within the reset cycle; after release, req0 wins the first tie again.
